// File: rtl/pwm_fade_controller_if.sv
// Control/status bundle between a PWM fade controller and its host.
// The host drives target/load/period_end; the controller returns duty/busy/done.
interface pwm_fade_controller_if #(
  parameter int unsigned bit_width = 16
);
  logic [bit_width-1:0] target;
  logic                 load;
  logic                 period_end;
  logic [bit_width-1:0] duty;
  logic                 busy;
  logic                 done;

  modport master (
    output target,
    output load,
    output period_end,
    input  duty,
    input  busy,
    input  done
  );

  modport slave (
    input  target,
    input  load,
    input  period_end,
    output duty,
    output busy,
    output done
  );
endinterface

// File: rtl/pwm_fade_controller.sv
// Ramps a PWM duty word toward a loaded target one step per tick, publishing it at period wrap.
// Optional PWM_FADE_BREATHE_EN: after reaching a non-zero target, ramps repeatedly target->0->target.
module pwm_fade_controller #(
  parameter int unsigned bit_width = 16,
  parameter int unsigned step      = 1,
  parameter int unsigned tick_div  = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  pwm_fade_controller_if.slave        bus
);

  localparam int unsigned CntW = (tick_div > 1) ? $clog2(tick_div) : 1;
  localparam int unsigned W1   = bit_width + 1;
  localparam logic [CntW-1:0]      CntMax = CntW'(tick_div - 1);
  localparam logic [W1-1:0]        StepW  = W1'(step);
  localparam logic [bit_width-1:0] StepN  = bit_width'(step);

  typedef enum logic [1:0] {StIdle, StUp, StDown, StHold} state_e;

  state_e               state_q;
  logic [bit_width-1:0] tgt_q;
  logic [bit_width-1:0] duty_int_q;
  logic [bit_width-1:0] duty_q;
  logic [CntW-1:0]      cnt_q;
  logic                 busy_q;
  logic                 done_q;
`ifdef PWM_FADE_BREATHE_EN
  // Set while descending toward 0 as part of a breathing cycle.
  logic                 breathe_q;
`endif

  logic                 cnt_run;
  logic                 tick;
  logic [W1-1:0]        up_sum;
  logic [W1-1:0]        down_lim;
  logic [bit_width-1:0] up_next;
  logic [bit_width-1:0] down_next;
  logic [bit_width-1:0] down_floor;

  always_comb begin
    cnt_run = (state_q == StUp) || (state_q == StDown);
`ifdef PWM_FADE_BREATHE_EN
    if ((state_q == StHold) && (tgt_q != '0)) begin
      cnt_run = 1'b1;
    end
    down_floor = (breathe_q || (state_q == StHold)) ? '0 : tgt_q;
`else
    down_floor = tgt_q;
`endif
    tick = cnt_run && (cnt_q == CntMax);

    // One extra bit so duty_int + step can never wrap past the target.
    up_sum  = {1'b0, duty_int_q} + StepW;
    up_next = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[bit_width-1:0];

    // Compare before subtracting so the result never drops below the floor.
    down_lim  = {1'b0, down_floor} + StepW;
    down_next = ({1'b0, duty_int_q} >= down_lim) ? (duty_int_q - StepN) : down_floor;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tgt_q      <= '0;
      duty_int_q <= '0;
      duty_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PWM_FADE_BREATHE_EN
      breathe_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;

      if (bus.period_end) begin
        duty_q <= duty_int_q;
      end

      if (tick) begin
        cnt_q <= '0;
      end else if (cnt_run) begin
        cnt_q <= cnt_q + CntW'(1);
      end

      if (bus.load) begin
        // A load on a tick cycle wins; the tick is dropped.
        tgt_q <= bus.target;
        cnt_q <= '0;
`ifdef PWM_FADE_BREATHE_EN
        breathe_q <= 1'b0;
`endif
        if (bus.target > duty_int_q) begin
          state_q <= StUp;
          busy_q  <= 1'b1;
        end else if (bus.target < duty_int_q) begin
          state_q <= StDown;
          busy_q  <= 1'b1;
        end else begin
          state_q <= StHold;
          done_q  <= 1'b1;
`ifdef PWM_FADE_BREATHE_EN
          busy_q  <= (bus.target != '0);
`else
          busy_q  <= 1'b0;
`endif
        end
      end else if (tick) begin
        unique case (state_q)
          StUp: begin
            duty_int_q <= up_next;
            if (up_next == tgt_q) begin
              state_q <= StHold;
              done_q  <= 1'b1;
`ifdef PWM_FADE_BREATHE_EN
              busy_q  <= (tgt_q != '0);
`else
              busy_q  <= 1'b0;
`endif
            end
          end
          StDown: begin
            duty_int_q <= down_next;
            if (down_next == down_floor) begin
              done_q <= 1'b1;
`ifdef PWM_FADE_BREATHE_EN
              if (breathe_q) begin
                state_q   <= StUp;
                breathe_q <= 1'b0;
              end else begin
                state_q <= StHold;
                busy_q  <= (tgt_q != '0);
              end
`else
              state_q <= StHold;
              busy_q  <= 1'b0;
`endif
            end
          end
`ifdef PWM_FADE_BREATHE_EN
          StHold: begin
            // Start the descending half of a breath; floor is 0 here.
            duty_int_q <= down_next;
            if (down_next == '0) begin
              done_q  <= 1'b1;
              state_q <= StUp;
            end else begin
              state_q   <= StDown;
              breathe_q <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.duty = duty_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Directed bench for pwm_fade_controller: closed-form ramp model checked every cycle,
// plus hand-computed literal expectations; a second instance exercises a large step.
module tb_pwm_fade_controller;
  localparam int TD = 4;
  localparam int ST = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_fade_controller_if #(.bit_width(8)) bus_a ();
  pwm_fade_controller_if #(.bit_width(8)) bus_b ();

  pwm_fade_controller #(.bit_width(8), .step(1), .tick_div(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pwm_fade_controller #(.bit_width(8), .step(100), .tick_div(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int done_seen = 0;
  bit model_en = 1'b1;

  // Model: a fade is fully described by start value, target and load edge.
  int m_s = 0;
  int m_t = 0;
  int m_l = 0;
  bit m_act = 1'b0;
  int m_duty = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  function automatic int dist_m();
    return (m_t > m_s) ? (m_t - m_s) : (m_s - m_t);
  endfunction

  function automatic int di_at(input int e);
    int moved;
    if (!m_act) return m_s;
    moved = ((e - m_l) / TD) * ST;
    if (moved > dist_m()) moved = dist_m();
    return (m_t >= m_s) ? (m_s + moved) : (m_s - moved);
  endfunction

  function automatic int busy_at(input int e);
    if (!m_act) return 0;
    return ((((e - m_l) / TD) * ST) < dist_m()) ? 1 : 0;
  endfunction

  function automatic int done_at(input int e);
    int k;
    if (!m_act) return 0;
    if (dist_m() == 0) return (e == m_l) ? 1 : 0;
    k = (e - m_l) / TD;
    return (((e - m_l) % TD) == 0 && (k * ST) >= dist_m() && ((k - 1) * ST) < dist_m()) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_s = 0;
    m_t = 0;
    m_l = edge_n;
    m_act = 1'b0;
    m_duty = 0;
  endtask

  // One clock: update the model from the inputs seen at the edge, compare at the falling edge.
  task automatic cyc();
    int prev;
    @(posedge clk);
    edge_n++;
    prev = di_at(edge_n - 1);
    if (rst) begin
      model_reset();
    end else begin
      if (bus_a.period_end) m_duty = prev;
      if (bus_a.load) begin
        m_s = prev;
        m_t = int'(bus_a.target);
        m_l = edge_n;
        m_act = 1'b1;
      end
    end
    @(negedge clk);
    if (bus_a.done) done_seen++;
    if (model_en) begin
      check("model_duty", int'(bus_a.duty), m_duty);
      check("model_busy", int'(bus_a.busy), busy_at(edge_n));
      check("model_done", int'(bus_a.done), done_at(edge_n));
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic load_a(input int t);
    bus_a.load = 1'b1;
    bus_a.target = 8'(t);
    cyc();
    bus_a.load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_a.load = 1'b1;
    bus_a.target = 8'd77;
    bus_a.period_end = 1'b1;
    bus_b.load = 1'b0;
    bus_b.target = 8'd0;
    bus_b.period_end = 1'b1;
    model_reset();

    // Load and period_end are ignored while reset is held.
    run(2);
    check("reset_duty", int'(bus_a.duty), 0);
    check("reset_busy", int'(bus_a.busy), 0);
    check("reset_done", int'(bus_a.done), 0);
    bus_a.load = 1'b0;
    rst = 1'b0;

`ifdef PWM_FADE_BREATHE_EN
    model_en = 1'b0;
    done_seen = 0;
    load_a(2);
    run(5); check("br_duty1a", int'(bus_a.duty), 1);
    run(3); check("br_done2a", int'(bus_a.done), 1); check("br_busy2a", int'(bus_a.busy), 1);
    run(1); check("br_duty2a", int'(bus_a.duty), 2);
    run(4); check("br_duty1b", int'(bus_a.duty), 1);
    run(3); check("br_done0", int'(bus_a.done), 1); check("br_busy0", int'(bus_a.busy), 1);
    run(1); check("br_duty0", int'(bus_a.duty), 0);
    run(4); check("br_duty1c", int'(bus_a.duty), 1);
    run(3); check("br_done2b", int'(bus_a.done), 1); check("br_busy2b", int'(bus_a.busy), 1);
    run(1); check("br_duty2b", int'(bus_a.duty), 2);
    check("br_done_count", done_seen, 3);
`else
    // First load right after reset: ramp 0 -> 3.
    load_a(3);
    check("up_busy_start", int'(bus_a.busy), 1);
    run(5); check("up_duty1", int'(bus_a.duty), 1);
    run(4); check("up_duty2", int'(bus_a.duty), 2);
    run(3); check("up_done", int'(bus_a.done), 1); check("up_busy_end", int'(bus_a.busy), 0);
    run(1); check("up_duty3", int'(bus_a.duty), 3); check("up_done_once", int'(bus_a.done), 0);

    // Loading the current value goes straight to hold with a done pulse.
    load_a(3);
    check("eq_done", int'(bus_a.done), 1);
    check("eq_busy", int'(bus_a.busy), 0);
    run(12); check("hold_duty", int'(bus_a.duty), 3);

    // Asynchronous reset mid-ramp clears outputs before any edge; no done.
    load_a(10);
    run(9);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_duty", int'(bus_a.duty), 0);
    check("async_busy", int'(bus_a.busy), 0);
    check("async_done", int'(bus_a.done), 0);
    bus_a.load = 1'b1;
    bus_a.target = 8'd99;
    run(2);
    bus_a.load = 1'b0;
    rst = 1'b0;

    // Retarget downward mid-ramp at duty 2.
    load_a(10);
    run(9); check("rt_duty2", int'(bus_a.duty), 2);
    done_seen = 0;
    load_a(0);
    check("rt_busy", int'(bus_a.busy), 1);
    run(5); check("rt_duty1", int'(bus_a.duty), 1);
    run(4); check("rt_duty0", int'(bus_a.duty), 0);
    run(5); check("rt_done_count", done_seen, 1); check("rt_busy_end", int'(bus_a.busy), 0);

    // Load landing on a tick edge: the tick is dropped.
    load_a(20);
    run(7);
    load_a(20);
    run(1); check("tick_drop_duty1", int'(bus_a.duty), 1);
    run(4); check("tick_drop_duty2", int'(bus_a.duty), 2);

    // Duty only follows the working value on period_end.
    rst = 1'b1;
    model_reset();
    run(1);
    rst = 1'b0;
    bus_a.period_end = 1'b0;
    load_a(5);
    run(30);
    check("pe_hold_duty", int'(bus_a.duty), 0);
    check("pe_hold_busy", int'(bus_a.busy), 0);
    bus_a.period_end = 1'b1;
    cyc();
    check("pe_pulse_duty", int'(bus_a.duty), 5);
    bus_a.period_end = 1'b0;
    run(3); check("pe_after_duty", int'(bus_a.duty), 5);
    bus_a.period_end = 1'b1;

    // Large step: 200 -> 250 must saturate at 250, never wrap to 44.
    bus_b.load = 1'b1;
    bus_b.target = 8'd200;
    cyc();
    bus_b.load = 1'b0;
    run(8);
    check("b_done200", int'(bus_b.done), 1);
    check("b_busy200", int'(bus_b.busy), 0);
    bus_b.load = 1'b1;
    bus_b.target = 8'd250;
    cyc();
    bus_b.load = 1'b0;
    check("b_busy250", int'(bus_b.busy), 1);
    run(4);
    check("b_done250", int'(bus_b.done), 1);
    check("b_busy_end", int'(bus_b.busy), 0);
    run(1); check("b_duty250", int'(bus_b.duty), 250);
    run(2); check("b_duty_hold", int'(bus_b.duty), 250); check("b_done_low", int'(bus_b.done), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_fade_controller.md
PWM_FADE_CONTROLLER -- requirements
Module: pwm_fade_controller

Interface
REQ-001 SHALL have parameter bit_width, default 16, the width of the duty word (matches the PWM counter width).
REQ-002 SHALL have parameter step, default 1, the duty increment/decrement applied per ramp tick.
REQ-003 SHALL have parameter tick_div, default 1000, the clock cycles per ramp tick (>=1).
REQ-004 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port target  input  bit_width  requested final duty value.
REQ-007 SHALL have port load  input  1  one-cycle strobe; captures target and starts a fade.
REQ-008 SHALL have port period_end  input  1  one-cycle pulse from the PWM counter at period wrap; duty output update point.
REQ-009 SHALL have port duty  output  bit_width  duty value presented to the PWM module.
REQ-010 SHALL have port busy  output  1  high while ramping.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the ramp reaches its endpoint.

Function
REQ-012 SHALL hold internal registers: tgt (captured target), duty_int (working duty), tick counter 0..tick_div-1, and state in {IDLE, UP, DOWN, HOLD}.
REQ-013 SHALL generate a tick on the cycle the tick counter equals tick_div-1; counter then wraps to 0; counter runs only in UP/DOWN and clears on load.
REQ-014 SHALL, on load=1 in any state, capture tgt<=target and on the next cycle enter UP if target>duty_int, DOWN if target<duty_int, else HOLD with done pulsed that cycle.
REQ-015 SHALL, on load coinciding with a tick, honour load and discard the tick.
REQ-016 SHALL, in UP on each tick, set duty_int<=min(duty_int+step, tgt) using bit_width+1 arithmetic; never wraps.
REQ-017 SHALL, in DOWN on each tick, set duty_int<=max(duty_int-step, tgt); never underflows below tgt or 0.
REQ-018 SHALL, when duty_int becomes equal to tgt in UP/DOWN, enter HOLD and assert done for exactly the following cycle.
REQ-019 SHALL drive busy=1 exactly when state is UP or DOWN, registered.
REQ-020 SHALL copy duty_int to duty only in cycles where period_end=1 (glitch-free update); duty holds otherwise.
REQ-021 SHALL, in IDLE and HOLD without load, keep duty_int and tgt unchanged.
REQ-022 SHALL retarget mid-ramp from the current duty_int with no reset of duty_int.

Reset
REQ-023 SHALL, while rst=1 and asynchronously, force state=IDLE, duty=0, duty_int=0, tgt=0, tick counter=0, busy=0, done=0.
REQ-024 SHALL ignore load and period_end while rst=1; first load is accepted on the first clock edge after rst deasserts.
REQ-025 SHALL abort any ramp in progress when reset is asserted mid-operation, without a done pulse.

Configuration
REQ-026 SHALL support macro PWM_FADE_BREATHE_EN; when defined, HOLD with tgt!=0 SHALL, on the next tick, ramp DOWN to 0, then UP to tgt, repeating until the next load, pulsing done at each endpoint arrival and keeping busy=1 throughout.
REQ-027 SHALL, without PWM_FADE_BREATHE_EN, remain in HOLD indefinitely until load; no breathing logic synthesised.

Verification (bit_width=8, step=1, tick_div=4, period_end tied 1, macro undefined unless stated)
REQ-028 SHALL cover: assert rst mid-cycle -> duty=0, busy=0, done=0 immediately without clock edge.
REQ-029 SHALL cover: load target=3 from 0 -> busy=1, duty steps 1,2,3 at 4-cycle spacing, done one cycle after reaching 3, busy=0.
REQ-030 SHALL cover: step=100, duty_int=200, load target=250 -> duty 250 after one tick (no wrap to 44), done pulsed.
REQ-031 SHALL cover: ramping toward 10 at duty=2, load target=0 -> DOWN, duty 1 then 0, single done.
REQ-032 SHALL cover: period_end held 0 through a ramp to 5 -> duty stays 0; single period_end pulse -> duty=5 next cycle.
REQ-033 SHALL cover: with PWM_FADE_BREATHE_EN, load target=2 -> duty sequence 1,2,1,0,1,2 with done at each of 2,0,2.
